// File: rtl/memory_write_control_if.sv
// rtl/memory_write_control_if.sv - video capture input and frame-buffer write port bundle
interface memory_write_control_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 16
);
  logic                  i_vsync;
  logic                  i_hsync;
  logic                  i_de;
  logic [DATA_WIDTH-1:0] i_data;
  logic [10:0]           i_hres;
  logic [10:0]           i_vres;
  logic                  o_wen;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  o_frame_done;
  logic                  o_frame_err;
  logic                  o_ovf;

  modport slave (
    input  i_vsync, i_hsync, i_de, i_data, i_hres, i_vres,
    output o_wen, o_waddr, o_wdata, o_frame_done, o_frame_err, o_ovf
  );

  modport master (
    output i_vsync, i_hsync, i_de, i_data, i_hres, i_vres,
    input  o_wen, o_waddr, o_wdata, o_frame_done, o_frame_err, o_ovf
  );
endinterface

// File: rtl/memory_write_control.sv
// rtl/memory_write_control.sv - frame-buffer write side: sync/DE capture, counters, write port
// Optional 2x2 subsampling when DOWNSCALE_EN is defined.
module memory_write_control #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_DEPTH = 512*512/4,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    rst_n,
  memory_write_control_if.slave   bus
);

  typedef enum logic [1:0] {S_WIDLE, S_WACTIVE, S_WDONE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(ADDR_DEPTH);

  state_t                state_q, state_d;
  logic                  vsync_q, de_q;
  logic [11:0]           col_q, col_d;
  logic [11:0]           row_q, row_d;
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;

  logic        vs_rise, de_fall, active, last_row, col_room, keep, accept;
  logic [11:0] hres12, vres12;
  logic        unused_hsync;

  assign unused_hsync = bus.i_hsync;

  assign vs_rise  = bus.i_vsync & ~vsync_q;
  assign de_fall  = ~bus.i_de & de_q;
  assign hres12   = {1'b0, bus.i_hres};
  assign vres12   = {1'b0, bus.i_vres};
  assign active   = (state_q == S_WACTIVE);
  assign last_row = (row_q == vres12 - 12'd1);
  assign col_room = (col_q < hres12);
`ifdef DOWNSCALE_EN
  assign keep = ~col_q[0] & ~row_q[0];
`else
  assign keep = 1'b1;
`endif
  // A pixel coinciding with the frame-start edge belongs to no frame and is dropped.
  assign accept = active & bus.i_de & col_room & keep & ~vs_rise;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WIDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WIDLE:   if (vs_rise) state_d = S_WACTIVE;
      S_WACTIVE: if (vs_rise)                    state_d = S_WACTIVE;
                 else if (de_fall && last_row)   state_d = S_WDONE;
      S_WDONE:   if (vs_rise) state_d = S_WACTIVE;
      default:   state_d = S_WIDLE;
    endcase
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    waddr_d = waddr_q;
    wen_d   = 1'b0;
    oaddr_d = oaddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = vs_rise & active;
    ovf_d   = ovf_q;
    if (vs_rise) begin
      col_d   = '0;
      row_d   = '0;
      waddr_d = '0;
      ovf_d   = 1'b0;
    end else if (active) begin
      if (de_fall) begin
        col_d  = '0;
        row_d  = row_q + 12'd1;
        done_d = last_row;
      end
      // Column counter advances on every in-range DE cycle so subsampling sees true parity.
      if (bus.i_de && col_room) col_d = col_q + 12'd1;
      if (accept) begin
        if (waddr_q < DEPTH_L) begin
          wen_d   = 1'b1;
          oaddr_d = waddr_q[ADDR_WIDTH-1:0];
          wdata_d = bus.i_data;
          waddr_d = waddr_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      waddr_q <= '0;
      wen_q   <= 1'b0;
      oaddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      vsync_q <= bus.i_vsync;
      de_q    <= bus.i_de;
      col_q   <= col_d;
      row_q   <= row_d;
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
      oaddr_q <= oaddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_wen        = wen_q;
  assign bus.o_waddr      = oaddr_q;
  assign bus.o_wdata      = wdata_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_frame_err  = err_q;
  assign bus.o_ovf        = ovf_q;

endmodule

// File: tb/tb_memory_write_control.sv
// tb/tb_memory_write_control.sv - directed self-checking bench for memory_write_control
module tb_memory_write_control;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  memory_write_control_if #(.DATA_WIDTH(24), .ADDR_WIDTH(4)) vif ();

  memory_write_control #(
    .DATA_WIDTH(24),
    .ADDR_DEPTH(16),
    .ADDR_WIDTH(4)
  ) dut (
    .i_clk (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle, then sample outputs 1 time unit after the edge.
  task automatic step(input logic vs, input logic de, input logic [23:0] d);
    vif.i_vsync = vs;
    vif.i_hsync = 1'b0;
    vif.i_de    = de;
    vif.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [3:0] a, input logic [23:0] d);
    chk({tag, "_wen"},   32'(vif.o_wen), 32'd1);
    chk({tag, "_waddr"}, 32'(vif.o_waddr), 32'(a));
    chk({tag, "_wdata"}, 32'(vif.o_wdata), 32'(d));
  endtask

  initial begin
    rst_n       = 1'b0;
    vif.i_vsync = 1'b0;
    vif.i_hsync = 1'b0;
    vif.i_de    = 1'b0;
    vif.i_data  = '0;
    vif.i_hres  = 11'd4;
    vif.i_vres  = 11'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",   32'(vif.o_wen), 32'd0);
    chk("rst_waddr", 32'(vif.o_waddr), 32'd0);
    chk("rst_wdata", 32'(vif.o_wdata), 32'd0);
    chk("rst_done",  32'(vif.o_frame_done), 32'd0);
    chk("rst_err",   32'(vif.o_frame_err), 32'd0);
    chk("rst_ovf",   32'(vif.o_ovf), 32'd0);
    rst_n = 1'b1;

`ifdef DOWNSCALE_EN
    vif.i_hres = 11'd4;
    vif.i_vres = 11'd4;
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    begin
      int n = 0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          step(0, 1, 24'(r*16 + c));
          if ((r % 2 == 0) && (c % 2 == 0)) begin
            chk_wr("ds", 4'(n), 24'(r*16 + c));
            n++;
          end else begin
            chk("ds_skip_wen", 32'(vif.o_wen), 32'd0);
          end
        end
        step(0, 0, 0);
        chk("ds_done", 32'(vif.o_frame_done), 32'(r == 3));
        step(0, 0, 0);
      end
      chk("ds_last_addr", 32'(vif.o_waddr), 32'd3);
      chk("ds_last_data", 32'(vif.o_wdata), 32'h22);
    end
`else
    // Two 4-pixel lines, vres=2
    step(0, 0, 0);
    step(1, 0, 0);
    chk("t1_err_from_idle", 32'(vif.o_frame_err), 32'd0);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 24'(8'h10 + i));
      chk_wr("t1_l0", 4'(i), 24'(8'h10 + i));
    end
    step(0, 0, 0);
    chk("t1_l0_wen_off", 32'(vif.o_wen), 32'd0);
    chk("t1_l0_done", 32'(vif.o_frame_done), 32'd0);
    chk("t1_hold_addr", 32'(vif.o_waddr), 32'd3);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 24'(8'h14 + i));
      chk_wr("t1_l1", 4'(4 + i), 24'(8'h14 + i));
    end
    step(0, 0, 0);
    chk("t1_done", 32'(vif.o_frame_done), 32'd1);
    step(0, 0, 0);
    chk("t1_done_1cyc", 32'(vif.o_frame_done), 32'd0);
    step(0, 1, 24'hAA);
    chk("t1_idle_after_done", 32'(vif.o_wen), 32'd0);
    step(0, 0, 0);

    // hres=3 with 5 DE cycles per line
    vif.i_hres = 11'd3;
    step(1, 0, 0);
    chk("t3_err_from_done", 32'(vif.o_frame_err), 32'd0);
    step(0, 0, 0);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 5; i++) begin
        step(0, 1, 24'(l*16 + i));
        if (i < 3) begin
          chk_wr("t3_w", 4'(l*3 + i), 24'(l*16 + i));
        end else begin
          chk("t3_drop_wen",  32'(vif.o_wen), 32'd0);
          chk("t3_hold_addr", 32'(vif.o_waddr), 32'(l*3 + 2));
          chk("t3_hold_data", 32'(vif.o_wdata), 32'(l*16 + 2));
        end
      end
      step(0, 0, 0);
      chk("t3_done", 32'(vif.o_frame_done), 32'(l == 1));
      step(0, 0, 0);
    end

    // Overflow with depth 16, hres=8
    vif.i_hres = 11'd8;
    vif.i_vres = 11'd4;
    step(1, 0, 0);
    step(0, 0, 0);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 8; i++) begin
        step(0, 1, 24'(l*8 + i));
        if (l*8 + i < 16) begin
          chk_wr("t4_w", 4'(l*8 + i), 24'(l*8 + i));
          chk("t4_no_ovf", 32'(vif.o_ovf), 32'd0);
        end else begin
          chk("t4_ovf_wen", 32'(vif.o_wen), 32'd0);
          chk("t4_ovf", 32'(vif.o_ovf), 32'd1);
        end
      end
      step(0, 0, 0);
    end
    chk("t4_ovf_sticky", 32'(vif.o_ovf), 32'd1);
    step(1, 0, 0);
    chk("t4_ovf_clear", 32'(vif.o_ovf), 32'd0);
    chk("t4_restart_err", 32'(vif.o_frame_err), 32'd1);
    step(0, 0, 0);
    chk("t4_err_1cyc", 32'(vif.o_frame_err), 32'd0);

    // Restart mid-frame, vsync edge coincident with DE and with DE fall
    vif.i_hres = 11'd4;
    vif.i_vres = 11'd2;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 24'(8'h30 + i));
      chk_wr("t5_l0", 4'(i), 24'(8'h30 + i));
    end
    step(0, 0, 0);
    chk("t5_l0_done", 32'(vif.o_frame_done), 32'd0);
    step(1, 1, 24'h55);
    chk("t5_vs_de_wen", 32'(vif.o_wen), 32'd0);
    chk("t5_err", 32'(vif.o_frame_err), 32'd1);
    chk("t5_no_done", 32'(vif.o_frame_done), 32'd0);
    step(0, 1, 24'h56);
    chk_wr("t5_first", 4'd0, 24'h56);
    chk("t5_err_off", 32'(vif.o_frame_err), 32'd0);
    vif.i_vres = 11'd1;
    step(1, 0, 0);
    chk("t5_vs_fall_done", 32'(vif.o_frame_done), 32'd0);
    chk("t5_vs_fall_err", 32'(vif.o_frame_err), 32'd1);
    step(0, 0, 0);
    step(0, 1, 24'h57);
    chk_wr("t5_after", 4'd0, 24'h57);
    step(0, 0, 0);
    chk("t5_done_vres1", 32'(vif.o_frame_done), 32'd1);

    // Reset mid-line
    vif.i_vres = 11'd2;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 24'h60);
    chk_wr("t6_a", 4'd0, 24'h60);
    step(0, 1, 24'h61);
    chk_wr("t6_b", 4'd1, 24'h61);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_wen",   32'(vif.o_wen), 32'd0);
    chk("t6_async_waddr", 32'(vif.o_waddr), 32'd0);
    chk("t6_async_wdata", 32'(vif.o_wdata), 32'd0);
    step(0, 1, 24'h62);
    chk("t6_in_rst_wen", 32'(vif.o_wen), 32'd0);
    #2 rst_n = 1'b1;
    step(0, 1, 24'h63);
    chk("t6_post_rst_wen0", 32'(vif.o_wen), 32'd0);
    step(0, 1, 24'h64);
    chk("t6_post_rst_wen1", 32'(vif.o_wen), 32'd0);
    step(0, 0, 0);
    chk("t6_post_rst_done", 32'(vif.o_frame_done), 32'd0);
    step(1, 0, 0);
    chk("t6_vs_wen", 32'(vif.o_wen), 32'd0);
    step(0, 1, 24'h70);
    chk_wr("t6_restart", 4'd0, 24'h70);
`endif

    step(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_write_control.md
# memory_write_control

Frame-memory write side of the frame memory controller. Captures an incoming active-high sync/DE video stream, counts columns and rows against the programmed resolution, and generates registered write enable, linear address and data for the frame buffer. The display timing and read logic later fetch from that buffer. The block also reports frame completion, short frames and address overflow.

## Interface
- DATA_WIDTH, 24, pixel width (RGB888).
- ADDR_DEPTH, 512*512/4, frame-buffer words.
- ADDR_WIDTH, $clog2(ADDR_DEPTH), write address width.

Ports:
- i_clk  input  1  pixel clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_vsync  input  1  frame sync, active-high; rising edge starts a frame.
- i_hsync  input  1  line sync, active-high; ignored for counting, line end taken from DE.
- i_de  input  1  data enable, active-high; one pixel per cycle while high.
- i_data  input  DATA_WIDTH  pixel data, valid when i_de=1.
- i_hres  input  11  active pixels per line (1..2047).
- i_vres  input  11  active lines per frame (1..2047).
- o_wen  output  1  memory write enable.
- o_waddr  output  ADDR_WIDTH  memory write address.
- o_wdata  output  DATA_WIDTH  memory write data.
- o_frame_done  output  1  one-cycle pulse after the last line of a full frame.
- o_frame_err  output  1  one-cycle pulse when vsync restarts a frame in progress.
- o_ovf  output  1  sticky; a write was dropped because the address reached ADDR_DEPTH.

## Operation
- Registered edge detect: vs_rise = i_vsync & ~vsync_d; de_fall = ~i_de & de_d.
- Counters:
  - colCnt (12b): increments per DE-high cycle and saturates at i_hres. Pixels with colCnt >= i_hres are dropped.
  - rowCnt (12b): increments on de_fall.
  - waddr (ADDR_WIDTH+1b): increments per accepted write.
- FSM states:
  - S_WIDLE (reset): no writes. Goes to S_WACTIVE on vs_rise.
  - S_WACTIVE: accept pixels.
    - On de_fall with rowCnt == i_vres-1: go to S_WDONE and pulse o_frame_done.
    - On vs_rise: restart the frame (counters cleared, stay in S_WACTIVE) and pulse o_frame_err.
  - S_WDONE: no writes; DE activity ignored. Goes to S_WACTIVE on vs_rise.
- On every vs_rise: colCnt, rowCnt and waddr clear to 0, and o_ovf clears.
- Pixel accepted when all hold: state == S_WACTIVE, i_de = 1, colCnt < i_hres, keep = 1.
  - keep is defined under Configuration.
- Accepted pixel with waddr < ADDR_DEPTH: write issued at waddr, then waddr+1.
- Accepted pixel with waddr >= ADDR_DEPTH: no write, o_ovf set.
- Coincident vs_rise and de_fall: vs_rise wins. Counters clear, no row increment, no frame_done.
- Coincident vs_rise and i_de=1: that cycle's pixel is dropped; the first write is on the next DE cycle.
- Arithmetic is unsigned. Comparisons zero-extend the 11b inputs to 12b.

## Timing
- Inputs sampled at edge N; o_wen, o_waddr and o_wdata are registered and valid after edge N+1. Write latency is 1 cycle.
- o_waddr and o_wdata hold their last value when o_wen = 0.
- o_frame_done asserts the cycle after the de_fall sample, for exactly 1 cycle. o_frame_err uses the same timing relative to vs_rise.
- o_ovf sets 1 cycle after the dropped pixel is sampled.
- Reset values: state S_WIDLE, all counters 0, o_wen 0, o_waddr 0, o_wdata 0, o_frame_done 0, o_frame_err 0, o_ovf 0.
- Reset asserted mid-frame: all outputs go to reset values immediately. After release, no writes occur until the next vs_rise.
- Throughput: 1 write per cycle, no backpressure.

## Configuration
- DOWNSCALE_EN defined: 2x2 subsampling. keep = ~colCnt[0] & ~rowCnt[0], so only even columns of even rows are stored. A 512x512 input exactly fills the default ADDR_DEPTH (65536 writes).
- DOWNSCALE_EN undefined: keep = 1, and every active pixel is stored. A 256x256 input fills the default depth; a 512x512 input sets o_ovf after 65536 writes.

## Test plan
- Reset, no macro, hres=4, vres=2, two 4-pixel lines of data 0x10..0x17 -> 8 writes at addresses 0..7 with matching data, each 1 cycle after its DE sample. o_frame_done pulses once, 1 cycle after the second de_fall.
- DOWNSCALE_EN, hres=4, vres=4, data = row*16+col -> 4 writes: addr 0..3, data 0x00, 0x02, 0x20, 0x22.
- No macro, hres=3, 5 DE cycles per line -> exactly 3 writes per line; columns 3..4 are dropped.
- No macro, ADDR_DEPTH=16, hres=8, vres=4 -> writes at addr 0..15 only. o_ovf rises on the 17th pixel, stays high until the next vsync rising edge, then clears.
- vsync rising edge after 1 of 2 lines (vres=2) -> o_frame_err pulses, no o_frame_done, and the next pixel is written at addr 0.
- rst_n dropped mid-line, then released mid-line -> o_wen stays 0 until the next vsync rising edge, then writing restarts at addr 0.
